bf_ctrl: RTL and testbench

Instruction sequencer for the Brainfuck CPU. Fetches 8-bit opcodes from program memory and moves the data pointer. Drives the 8-bit ALU (one-hot nochange/decrement/increment) for read-modify-write of the current cell. Handles bracket matching by depth-counted scanning and I/O via valid/ready handshakes.

---
 rtl/bf_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_bf_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_ctrl.sv
// Brainfuck CPU sequencer: fetches opcodes, moves the data pointer, drives the
// external ALU for cell read-modify-write, matches brackets by depth-counted scans.
module bf_ctrl #(
    parameter int PC_W    = 10,
    parameter int DP_W    = 8,
    parameter int DEPTH_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_rdata,
    output logic [DP_W-1:0] dmem_addr,
    input  logic [7:0]      dmem_rdata,
    output logic            dmem_we,
    output logic [7:0]      dmem_wdata,
    output logic [7:0]      alu_a,
    output logic            alu_nochange,
    output logic            alu_decrement,
    output logic            alu_increment,
    input  logic [7:0]      alu_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_SCAN_F, S_SCAN_B, S_OUT, S_IN, S_HALT
    } state_t;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OPEN  = 8'h5B;
    localparam logic [7:0] OP_CLOSE = 8'h5D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_HALT  = 8'h00;

    localparam logic [PC_W-1:0]    PC_ONE    = PC_W'(1);
    localparam logic [PC_W-1:0]    PC_LAST   = '1;
    localparam logic [DP_W-1:0]    DP_ONE    = DP_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DP_W-1:0]    dp_q, dp_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            dp_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dp_q    <= dp_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        dp_d          = dp_q;
        depth_d       = depth_q;
        err_d         = err_q;
        dmem_we       = 1'b0;
        dmem_wdata    = alu_out;
        alu_nochange  = 1'b1;
        alu_decrement = 1'b0;
        alu_increment = 1'b0;
        out_valid     = 1'b0;
        in_ready      = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    dp_d    = '0;
                    depth_d = '0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                case (imem_rdata)
                    OP_INC: begin
                        alu_nochange  = 1'b0;
                        alu_increment = 1'b1;
                        dmem_we       = 1'b1;
                        pc_d          = pc_q + PC_ONE;
                    end
                    OP_DEC: begin
                        alu_nochange  = 1'b0;
                        alu_decrement = 1'b1;
                        dmem_we       = 1'b1;
                        pc_d          = pc_q + PC_ONE;
                    end
                    OP_RIGHT: begin
                        dp_d = dp_q + DP_ONE;
                        pc_d = pc_q + PC_ONE;
                    end
                    OP_LEFT: begin
                        dp_d = dp_q - DP_ONE;
                        pc_d = pc_q + PC_ONE;
                    end
                    OP_OPEN: begin
                        pc_d = pc_q + PC_ONE;
                        if (dmem_rdata == 8'h00) begin
                            depth_d = DEPTH_ONE;
                            state_d = S_SCAN_F;
                        end
                    end
                    OP_CLOSE: begin
                        if (dmem_rdata != 8'h00) begin
                            depth_d = DEPTH_ONE;
                            pc_d    = pc_q - PC_ONE;
                            state_d = S_SCAN_B;
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                    OP_OUT:  state_d = S_OUT;
                    OP_IN:   state_d = S_IN;
                    OP_HALT: state_d = S_HALT;
                    default: pc_d = pc_q + PC_ONE;
                endcase
            end
            // A match on the last/first address still wins over the end-of-memory error.
            S_SCAN_F: begin
                if (imem_rdata == OP_CLOSE && depth_q == DEPTH_ONE) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_RUN;
                end else if ((imem_rdata == OP_OPEN && depth_q == DEPTH_MAX) || pc_q == PC_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_q + PC_ONE;
                    if (imem_rdata == OP_OPEN)       depth_d = depth_q + DEPTH_ONE;
                    else if (imem_rdata == OP_CLOSE) depth_d = depth_q - DEPTH_ONE;
                end
            end
            S_SCAN_B: begin
                if (imem_rdata == OP_OPEN && depth_q == DEPTH_ONE) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_RUN;
                end else if ((imem_rdata == OP_CLOSE && depth_q == DEPTH_MAX) || pc_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_q - PC_ONE;
                    if (imem_rdata == OP_CLOSE)     depth_d = depth_q + DEPTH_ONE;
                    else if (imem_rdata == OP_OPEN) depth_d = depth_q - DEPTH_ONE;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_RUN;
                end
            end
            S_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = in_data;
                    pc_d       = pc_q + PC_ONE;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign dmem_addr = dp_q;
    assign alu_a     = dmem_rdata;
    assign out_data  = dmem_rdata;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done      = (state_q == S_HALT);
    assign error     = err_q;

endmodule

// File: tb/tb_bf_ctrl.sv
// Bench for bf_ctrl: memories, ALU and handshake partners around the DUT, with an
// interpreter-style reference model feeding an output scoreboard.
module tb_bf_ctrl;
    localparam int PC_W = 10;
    localparam int DP_W = 8;
    localparam int DEPTH_W = 6;
    localparam int PC_N = 1 << PC_W;
    localparam int DEPTH_MAXV = (1 << DEPTH_W) - 1;
    localparam logic [7:0] C_INC = 8'h2B, C_DEC = 8'h2D, C_RIGHT = 8'h3E, C_LEFT = 8'h3C;
    localparam logic [7:0] C_OPEN = 8'h5B, C_CLOSE = 8'h5D, C_OUT = 8'h2E, C_IN = 8'h2C;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, done, error, dmem_we, alu_nochange, alu_decrement, alu_increment;
    logic out_valid, out_ready, in_valid, in_ready;
    logic [PC_W-1:0] imem_addr;
    logic [DP_W-1:0] dmem_addr;
    logic [7:0] imem_rdata, dmem_rdata, dmem_wdata, alu_a, alu_out, out_data, in_data;

    logic [7:0] imem [PC_N];
    logic [7:0] dmem [256];
    logic [7:0] ref_mem [256];
    int         in_delays [64];
    int         out_delays [64];
    logic [7:0] in_bytes [64];
    logic [7:0] exp_q [$];
    int         rd_idx;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign alu_out = alu_increment ? alu_a + 8'd1 : (alu_decrement ? alu_a - 8'd1 : alu_a);

    initial forever begin
        @(posedge clk);
        if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    bf_ctrl #(.PC_W(PC_W), .DP_W(DP_W), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .alu_a(alu_a), .alu_nochange(alu_nochange), .alu_decrement(alu_decrement),
        .alu_increment(alu_increment), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
    );

    function automatic void check(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endfunction

    // Handshake partners and output monitor, all sampled/driven on the falling edge.
    initial begin
        int ihs = 0, ohs = 0, icnt = 0, ocnt = 0;
        logic out_wait = 1'b0, in_wait = 1'b0;
        logic [7:0] held = 8'h00;
        in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00; rd_idx = 0;
        forever begin
            @(negedge clk);
            check("alu_onehot", int'(alu_nochange) + int'(alu_decrement) + int'(alu_increment), 1);
            if (rst) begin
                in_valid = 1'b0; out_ready = 1'b0; out_wait = 1'b0; in_wait = 1'b0;
                icnt = 0; ocnt = 0;
            end else begin
                if (start) begin
                    ihs = 0; ohs = 0; icnt = 0; ocnt = 0; rd_idx = 0;
                end
                if (out_wait) begin
                    check("out_valid_hold", out_valid, 1);
                    check("out_data_hold", out_data, held);
                end
                if (in_wait) check("in_ready_hold", in_ready, 1);
                if (out_valid) begin
                    if (!out_ready) begin
                        if (ocnt >= out_delays[ohs % 64]) out_ready = 1'b1;
                        else ocnt++;
                    end
                    if (out_ready) begin
                        if (rd_idx < exp_q.size()) check("out_data", out_data, exp_q[rd_idx]);
                        else check("out_unexpected", 1, 0);
                        rd_idx++;
                    end
                end else begin
                    if (out_ready) ohs++;
                    out_ready = 1'b0;
                    ocnt = 0;
                end
                out_wait = out_valid && !out_ready;
                held = out_data;
                if (in_ready) begin
                    if (!in_valid) begin
                        if (icnt >= in_delays[ihs % 64]) begin
                            in_data = in_bytes[ihs % 64];
                            in_valid = 1'b1;
                        end else icnt++;
                    end
                end else begin
                    if (in_valid) ihs++;
                    in_valid = 1'b0;
                    icnt = 0;
                end
                in_wait = in_ready && !in_valid;
            end
        end
    end

    // Bracket search from p in direction dir; one cycle per examined opcode.
    task automatic scan(input int p, input int dir, inout int cyc, output int np, output bit err);
        int d = 1;
        int i = p + dir;
        logic [7:0] op;
        err = 1'b0;
        np = p;
        forever begin
            cyc++;
            op = imem[i];
            if (op == (dir > 0 ? C_CLOSE : C_OPEN)) begin
                if (d == 1) begin
                    np = (i + 1) % PC_N;
                    return;
                end
                d--;
            end else if (op == (dir > 0 ? C_OPEN : C_CLOSE)) begin
                if (d == DEPTH_MAXV) begin
                    err = 1'b1;
                    return;
                end
                d++;
            end
            if (i == (dir > 0 ? PC_N - 1 : 0)) begin
                err = 1'b1;
                return;
            end
            i += dir;
        end
    endtask

    // Brainfuck interpreter with a cycle cost per operation, counted after start is taken.
    task automatic run_model(output int cyc, output bit err);
        int pc = 0, dp = 0, ih = 0, oh = 0, steps = 0;
        logic [7:0] op;
        bit stop = 1'b0;
        cyc = 0;
        err = 1'b0;
        exp_q.delete();
        while (!stop && steps < 100000) begin
            steps++;
            op = imem[pc];
            cyc++;
            if (op == C_INC) begin
                ref_mem[dp] = ref_mem[dp] + 8'd1; pc = (pc + 1) % PC_N;
            end else if (op == C_DEC) begin
                ref_mem[dp] = ref_mem[dp] - 8'd1; pc = (pc + 1) % PC_N;
            end else if (op == C_RIGHT) begin
                dp = (dp + 1) % 256; pc = (pc + 1) % PC_N;
            end else if (op == C_LEFT) begin
                dp = (dp + 255) % 256; pc = (pc + 1) % PC_N;
            end else if (op == C_OPEN) begin
                if (ref_mem[dp] == 8'h00) scan(pc, 1, cyc, pc, err);
                else pc = (pc + 1) % PC_N;
                stop = err;
            end else if (op == C_CLOSE) begin
                if (ref_mem[dp] != 8'h00) scan(pc, -1, cyc, pc, err);
                else pc = (pc + 1) % PC_N;
                stop = err;
            end else if (op == C_OUT) begin
                exp_q.push_back(ref_mem[dp]);
                cyc += 1 + out_delays[oh]; oh++; pc = (pc + 1) % PC_N;
            end else if (op == C_IN) begin
                ref_mem[dp] = in_bytes[ih];
                cyc += 1 + in_delays[ih]; ih++; pc = (pc + 1) % PC_N;
            end else if (op == 8'h00) begin
                stop = 1'b1;
            end else begin
                pc = (pc + 1) % PC_N;
            end
        end
    endtask

    task automatic setup(input string prog, input bit rand_mem);
        for (int i = 0; i < PC_N; i++) imem[i] = (i < prog.len()) ? prog[i] : 8'h00;
        for (int i = 0; i < 256; i++) dmem[i] <= rand_mem ? 8'($urandom_range(0, 63)) : 8'h00;
        for (int i = 0; i < 64; i++) begin
            in_delays[i] = 0;
            out_delays[i] = 0;
            in_bytes[i] = 8'($urandom_range(0, 255));
        end
        #1;
    endtask

    task automatic run_test(input string name, input int restart_at);
        int exp_cyc, cyc, nd;
        bit exp_err, timeout;
        for (int i = 0; i < 256; i++) ref_mem[i] = dmem[i];
        run_model(exp_cyc, exp_err);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        timeout = 1'b1;
        for (int k = 0; k < exp_cyc + 20; k++) begin
            @(negedge clk);
            if (done) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk);
            cyc++;
            if (restart_at > 0 && cyc == restart_at) begin
                #1 start = 1'b1;
                @(posedge clk);
                cyc++;
                #1 start = 1'b0;
            end
        end
        nd = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) nd++;
        check($sformatf("%s timeout", name), timeout, 0);
        check($sformatf("%s cycles", name), cyc, exp_cyc);
        check($sformatf("%s error", name), error, exp_err);
        check($sformatf("%s done", name), done, 1);
        check($sformatf("%s busy", name), busy, 0);
        check($sformatf("%s outputs", name), rd_idx, exp_q.size());
        check($sformatf("%s mem_diffs", name), nd, 0);
    endtask

    task automatic gen_random();
        string s = "";
        int loops = 0;
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 9))
                0, 9: s = {s, "+"};
                1: s = {s, "-"};
                2: s = {s, ">"};
                3: s = {s, "<"};
                4: s = {s, "."};
                5: s = {s, ","};
                6: s = {s, ($urandom_range(0, 1) != 0) ? "A" : " "};
                7: if (loops < 3) begin s = {s, "[-]"}; loops++; end
                default: s = {s, "[-][+.,>]"};
            endcase
        end
        setup(s, 1'b1);
        for (int i = 0; i < 64; i++) begin
            in_delays[i] = $urandom_range(0, 3);
            out_delays[i] = $urandom_range(0, 3);
        end
    endtask

    initial begin
        setup("", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 0);
        check("rst dmem_we", dmem_we, 0);
        check("rst alu_nochange", alu_nochange, 1);
        check("rst imem_addr", imem_addr, 0);
        check("rst dmem_addr", dmem_addr, 0);
        @(posedge clk); #1 rst = 1'b0;

        setup("+.", 1'b0); dmem[0] <= 8'hAD; #1;
        run_test("inc_out", 0);
        setup("->-<.", 1'b0);
        run_test("dec_wrap", 0);
        setup("<+.", 1'b0);
        run_test("dp_wrap", 0);
        setup("[+[+]]+.", 1'b0);
        run_test("skip_nested", 0);
        setup("+++[-].", 1'b0);
        run_test("loop3", 3);
        setup(",.", 1'b0); in_delays[0] = 5; out_delays[0] = 3; in_bytes[0] = 8'h41;
        run_test("io_wait", 0);
        setup("[", 1'b0);
        run_test("unmatched_open", 0);
        setup("+]", 1'b0);
        run_test("unmatched_close", 0);
        begin
            string s = "";
            for (int i = 0; i < 64; i++) s = {s, "["};
            setup(s, 1'b0);
        end
        run_test("depth_ovf", 0);

        for (int r = 0; r < 12; r++) begin
            gen_random();
            run_test($sformatf("rand%0d", r), 0);
        end

        setup("[", 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_scan busy", busy, 0);
        check("rst_scan done", done, 0);
        @(posedge clk); #1 rst = 1'b0;

        setup("+.", 1'b0); dmem[0] <= 8'h10; out_delays[0] = 50; #1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        check("rst_out reach", out_valid, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_out busy", busy, 0);
        check("rst_out out_valid", out_valid, 0);
        check("rst_out dmem_we", dmem_we, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rst_out cell", dmem[0], 8'h11);

        setup(",", 1'b0); dmem[0] <= 8'h33; in_delays[0] = 50; #1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        check("rst_in reach", in_ready, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_in busy", busy, 0);
        check("rst_in in_ready", in_ready, 0);
        check("rst_in dmem_we", dmem_we, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rst_in cell", dmem[0], 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
